// File: rtl/mfp_irq_ctrl_if.sv
// Bus bundle between the CPU side and the MFP interrupt controller.
// master: drives IRQ_IN, ADDR, WE, DAT_I, IACK; slave: DAT_O, ACK_VALID, VECTOR, IRQ_N.
interface mfp_irq_ctrl_if;
    logic [15:0] IRQ_IN;
    logic [3:0]  ADDR;
    logic        WE;
    logic [7:0]  DAT_I;
    logic [7:0]  DAT_O;
    logic        IACK;
    logic        ACK_VALID;
    logic [7:0]  VECTOR;
    logic        IRQ_N;

    modport master (
        output IRQ_IN, ADDR, WE, DAT_I, IACK,
        input  DAT_O, ACK_VALID, VECTOR, IRQ_N
    );

    modport slave (
        input  IRQ_IN, ADDR, WE, DAT_I, IACK,
        output DAT_O, ACK_VALID, VECTOR, IRQ_N
    );
endinterface

// File: rtl/mfp_irq_ctrl.sv
// MFP interrupt controller: IER/IPR/ISR/IMR/VR banks, priority encode, IACK vectoring.
// Ports: CLK, RST_N (async active-low), bus (slave modport of mfp_irq_ctrl_if).
module mfp_irq_ctrl #(
    parameter int NUM_CH = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    mfp_irq_ctrl_if.slave bus
);
    localparam int CW = $clog2(NUM_CH);

    logic [NUM_CH-1:0] ier, ipr, isr, imr, irq_q;
    logic [7:0]        vr;
    logic [7:0]        vector;
    logic              ack_valid;
    logic              irq_n;

    logic [NUM_CH-1:0] ier_n, imr_n, ipr_n, isr_n;
    logic [7:0]        vr_n;
    logic [NUM_CH-1:0] set_v, ipr_clr, isr_keep;
    logic [NUM_CH-1:0] above, elig, ack_oh;
    logic              isr_wipe;
    logic              hit;
    logic [CW-1:0]     sel;

    // Only enabled rising edges latch into IPR.
    assign set_v = bus.IRQ_IN & ~irq_q & ier;

    // Register writes. Bank A (even addr) is channels 15..8.
    always_comb begin
        ier_n    = ier;
        imr_n    = imr;
        vr_n     = vr;
        ipr_clr  = '0;
        isr_keep = '1;
        isr_wipe = 1'b0;
        if (bus.WE) begin
            case (bus.ADDR)
                4'd0: begin
                    ier_n[15:8]   = bus.DAT_I;
                    ipr_clr[15:8] = ~bus.DAT_I;
                end
                4'd1: begin
                    ier_n[7:0]   = bus.DAT_I;
                    ipr_clr[7:0] = ~bus.DAT_I;
                end
                4'd2: ipr_clr[15:8] = ~bus.DAT_I;
                4'd3: ipr_clr[7:0]  = ~bus.DAT_I;
                4'd4: isr_keep[15:8] = bus.DAT_I;
                4'd5: isr_keep[7:0]  = bus.DAT_I;
                4'd6: imr_n[15:8] = bus.DAT_I;
                4'd7: imr_n[7:0]  = bus.DAT_I;
                4'd8: begin
                    vr_n     = bus.DAT_I;
                    isr_wipe = ~bus.DAT_I[3];
                end
                default: ;
            endcase
        end
    end

    // In S mode a channel is eligible only if no ISR bit sits at or above it.
    always_comb begin
        above = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            above[i] = ((isr >> i) == '0);
        end
    end

    assign elig = ipr & imr & (vr[3] ? above : '1);

    // Highest index wins.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (elig[i]) begin
                sel = CW'(i);
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        ack_oh = '0;
        if (bus.IACK && hit) begin
            ack_oh[sel] = 1'b1;
        end
    end

    // New edges win over any clear in the same cycle.
    assign ipr_n = (ipr & ~(ipr_clr | ack_oh)) | set_v;
    assign isr_n = (isr_wipe ? '0 : (isr & isr_keep))
                 | (vr[3] ? ack_oh : '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ier       <= '0;
            ipr       <= '0;
            isr       <= '0;
            imr       <= '0;
            vr        <= '0;
            irq_q     <= '0;
            vector    <= '0;
            ack_valid <= 1'b0;
            irq_n     <= 1'b1;
        end else begin
            ier       <= ier_n;
            imr       <= imr_n;
            vr        <= vr_n;
            ipr       <= ipr_n;
            isr       <= isr_n;
            irq_q     <= bus.IRQ_IN;
            irq_n     <= ~|elig;
            ack_valid <= bus.IACK;
            if (bus.IACK) begin
                vector <= hit ? {vr[7:4], sel} : 8'h18;
            end
        end
    end

    always_comb begin
        bus.DAT_O = 8'h00;
        case (bus.ADDR)
            4'd0: bus.DAT_O = ier[15:8];
            4'd1: bus.DAT_O = ier[7:0];
            4'd2: bus.DAT_O = ipr[15:8];
            4'd3: bus.DAT_O = ipr[7:0];
            4'd4: bus.DAT_O = isr[15:8];
            4'd5: bus.DAT_O = isr[7:0];
            4'd6: bus.DAT_O = imr[15:8];
            4'd7: bus.DAT_O = imr[7:0];
            4'd8: bus.DAT_O = vr;
            default: bus.DAT_O = 8'h00;
        endcase
    end

    assign bus.ACK_VALID = ack_valid;
    assign bus.VECTOR    = vector;
    assign bus.IRQ_N     = irq_n;
endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// Self-checking bench for mfp_irq_ctrl: register table, directed
// corner sequences, and randomized traffic against a channel-level model.
module tb_mfp_irq_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mfp_irq_ctrl_if bus();

    mfp_irq_ctrl #(.NUM_CH(16)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic       we;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    logic [15:0] m_ier, m_ipr, m_isr, m_imr, m_prev;
    logic [7:0]  m_vr, m_vec;
    logic        m_av, m_irqn;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.ADDR  = a;
        bus.WE    = 1'b1;
        bus.DAT_I = d;
        tick();
        bus.WE = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        bus.ADDR = a;
        #1;
        d = bus.DAT_O;
    endtask

    task automatic pulse(input logic [15:0] m);
        bus.IRQ_IN = bus.IRQ_IN | m;
        tick();
        bus.IRQ_IN = bus.IRQ_IN & ~m;
    endtask

    task automatic iack();
        bus.IACK = 1'b1;
        tick();
        bus.IACK = 1'b0;
    endtask

    task automatic do_reset();
        bus.IRQ_IN = '0;
        bus.ADDR   = '0;
        bus.WE     = 1'b0;
        bus.DAT_I  = '0;
        bus.IACK   = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_ier  = '0;
        m_ipr  = '0;
        m_isr  = '0;
        m_imr  = '0;
        m_prev = '0;
        m_vr   = '0;
        m_vec  = '0;
        m_av   = 1'b0;
        m_irqn = 1'b1;
    endtask

    function automatic logic [7:0] m_read(input logic [3:0] a);
        int base;
        base = a[0] ? 0 : 8;
        case (a)
            4'd0, 4'd1: return m_ier[base +: 8];
            4'd2, 4'd3: return m_ipr[base +: 8];
            4'd4, 4'd5: return m_isr[base +: 8];
            4'd6, 4'd7: return m_imr[base +: 8];
            4'd8:       return m_vr;
            default:    return 8'h00;
        endcase
    endfunction

    // One clock of the model: decide from pre-edge state, then commit.
    task automatic m_step(input logic [15:0] irq, input logic [3:0] a,
                          input logic we, input logic [7:0] d,
                          input logic ack);
        int h;
        int best;
        int base;
        logic [15:0] ev, n_ier, n_ipr, n_isr, n_imr;
        logic [7:0]  n_vr;
        h    = -1;
        best = -1;
        for (int c = 0; c < 16; c++)
            if (m_isr[c]) h = c;
        for (int c = 0; c < 16; c++)
            if (m_ipr[c] && m_imr[c] && (!m_vr[3] || c > h)) best = c;
        ev    = irq & ~m_prev & m_ier;
        n_ier = m_ier;
        n_ipr = m_ipr;
        n_isr = m_isr;
        n_imr = m_imr;
        n_vr  = m_vr;
        base  = a[0] ? 0 : 8;
        if (we) begin
            case (a)
                4'd0, 4'd1: begin
                    n_ier[base +: 8] = d;
                    n_ipr[base +: 8] = n_ipr[base +: 8] & d;
                end
                4'd2, 4'd3: n_ipr[base +: 8] = n_ipr[base +: 8] & d;
                4'd4, 4'd5: n_isr[base +: 8] = n_isr[base +: 8] & d;
                4'd6, 4'd7: n_imr[base +: 8] = d;
                4'd8: begin
                    n_vr = d;
                    if (!d[3]) n_isr = '0;
                end
                default: ;
            endcase
        end
        if (ack) begin
            if (best < 0) begin
                m_vec = 8'h18;
            end else begin
                m_vec = {m_vr[7:4], 4'(best)};
                n_ipr[best] = 1'b0;
                if (m_vr[3]) n_isr[best] = 1'b1;
            end
        end
        n_ipr  = n_ipr | ev;
        m_irqn = (best < 0);
        m_av   = ack;
        m_prev = irq;
        m_ier  = n_ier;
        m_ipr  = n_ipr;
        m_isr  = n_isr;
        m_imr  = n_imr;
        m_vr   = n_vr;
    endtask

    function automatic vec_t v(input logic [3:0] a, input logic we,
                               input logic [7:0] d, input logic [7:0] e);
        vec_t r;
        r.a   = a;
        r.we  = we;
        r.d   = d;
        r.exp = e;
        return r;
    endfunction

    initial begin
        logic [7:0]  rv;
        logic [7:0]  acc;
        logic [15:0] r_irq;
        logic [3:0]  ra;
        logic        rwe;
        logic [7:0]  rd_;
        logic        rack;

        for (int i = 0; i < 9; i++) tbl.push_back(v(4'(i), 1'b0, 8'h00, 8'h00));
        tbl.push_back(v(4'hF, 1'b0, 8'h00, 8'h00));
        tbl.push_back(v(4'd0, 1'b1, 8'hA5, 8'hA5));
        tbl.push_back(v(4'd7, 1'b1, 8'h3C, 8'h3C));
        tbl.push_back(v(4'd8, 1'b1, 8'h47, 8'h47));
        tbl.push_back(v(4'd2, 1'b1, 8'hFF, 8'h00));
        tbl.push_back(v(4'd5, 1'b1, 8'hFF, 8'h00));
        tbl.push_back(v(4'd9, 1'b1, 8'h55, 8'h00));
        tbl.push_back(v(4'd6, 1'b1, 8'h81, 8'h81));
        tbl.push_back(v(4'd7, 1'b0, 8'h00, 8'h3C));
        tbl.push_back(v(4'd0, 1'b1, 8'h00, 8'h00));
        tbl.push_back(v(4'd1, 1'b0, 8'h00, 8'h00));

        do_reset();
        chk("rst_irq_n", bus.IRQ_N, 1);
        chk("rst_ack_valid", bus.ACK_VALID, 0);
        chk("rst_vector", bus.VECTOR, 0);
        foreach (tbl[i]) begin
            if (tbl[i].we) wr(tbl[i].a, tbl[i].d);
            rd(tbl[i].a, rv);
            chk($sformatf("tbl%0d_addr%0d", i, tbl[i].a), rv, tbl[i].exp);
        end

        // Single channel round trip.
        do_reset();
        wr(4'd1, 8'h01);
        wr(4'd7, 8'h01);
        wr(4'd8, 8'h40);
        pulse(16'h0001);
        rd(4'd3, rv);
        chk("basic_iprb", rv, 8'h01);
        chk("basic_irq_n_n1", bus.IRQ_N, 1);
        tick();
        chk("basic_irq_n_n2", bus.IRQ_N, 0);
        iack();
        chk("basic_ack_valid", bus.ACK_VALID, 1);
        chk("basic_vector", bus.VECTOR, 8'h40);
        rd(4'd3, rv);
        chk("basic_iprb_clr", rv, 8'h00);
        tick();
        chk("basic_ack_drop", bus.ACK_VALID, 0);
        chk("basic_irq_n_hi", bus.IRQ_N, 1);

        // S mode nesting.
        do_reset();
        wr(4'd0, 8'hFF);
        wr(4'd1, 8'hFF);
        wr(4'd6, 8'hFF);
        wr(4'd7, 8'hFF);
        wr(4'd8, 8'h48);
        pulse(16'h2020);
        tick();
        iack();
        chk("smode_vec1", bus.VECTOR, 8'h4D);
        rd(4'd4, rv);
        chk("smode_isra", rv, 8'h20);
        iack();
        chk("smode_spur_valid", bus.ACK_VALID, 1);
        chk("smode_spur_vec", bus.VECTOR, 8'h18);
        wr(4'd4, 8'hDF);
        iack();
        chk("smode_vec2", bus.VECTOR, 8'h45);

        // Masked pending becomes eligible on unmask.
        do_reset();
        wr(4'd0, 8'hFF);
        pulse(16'h1000);
        rd(4'd2, rv);
        chk("mask_ipra", rv, 8'h10);
        tick();
        chk("mask_irq_n_hi", bus.IRQ_N, 1);
        wr(4'd6, 8'h10);
        tick();
        chk("mask_irq_n_lo", bus.IRQ_N, 0);

        // Set wins over clear in the same cycle.
        do_reset();
        wr(4'd1, 8'h02);
        pulse(16'h0002);
        tick();
        bus.IRQ_IN[1] = 1'b1;
        wr(4'd3, 8'hFD);
        bus.IRQ_IN[1] = 1'b0;
        rd(4'd3, rv);
        chk("setwins_iprb", rv, 8'h02);

        // Level held high sets once; IER clear drops pending.
        do_reset();
        wr(4'd1, 8'h01);
        bus.IRQ_IN[0] = 1'b1;
        tick();
        rd(4'd3, rv);
        chk("level_set", rv, 8'h01);
        wr(4'd3, 8'hFE);
        repeat (3) tick();
        rd(4'd3, rv);
        chk("level_once", rv, 8'h00);
        bus.IRQ_IN[0] = 1'b0;
        tick();
        bus.IRQ_IN[0] = 1'b1;
        tick();
        rd(4'd3, rv);
        chk("level_reedge", rv, 8'h01);
        wr(4'd1, 8'h00);
        rd(4'd3, rv);
        chk("ier_clr_ipr", rv, 8'h00);
        bus.IRQ_IN[0] = 1'b0;

        // Reset in the middle of an acknowledge.
        do_reset();
        wr(4'd1, 8'h01);
        wr(4'd7, 8'h01);
        wr(4'd8, 8'h40);
        pulse(16'h0001);
        tick();
        bus.IACK = 1'b1;
        #3;
        rst_n = 1'b0;
        tick();
        bus.IACK = 1'b0;
        chk("rstack_av0", bus.ACK_VALID, 0);
        tick();
        chk("rstack_av1", bus.ACK_VALID, 0);
        rst_n = 1'b1;
        acc = 8'h00;
        for (int i = 0; i < 9; i++) begin
            rd(4'(i), rv);
            acc = acc | rv;
        end
        chk("rstack_regs", acc, 8'h00);
        chk("rstack_irq_n", bus.IRQ_N, 1);
        iack();
        chk("rstack_first_av", bus.ACK_VALID, 1);
        chk("rstack_first_vec", bus.VECTOR, 8'h18);

        // Randomized traffic against the model.
        do_reset();
        r_irq = '0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 2) == 0)
                r_irq = 16'($urandom) & 16'($urandom);
            ra   = 4'($urandom_range(0, 9));
            rwe  = ($urandom_range(0, 2) == 0);
            rd_  = 8'($urandom);
            if (ra < 4'd8) rd_ = rd_ | 8'($urandom);
            rack = ($urandom_range(0, 3) == 0);
            bus.IRQ_IN = r_irq;
            bus.ADDR   = ra;
            bus.WE     = rwe;
            bus.DAT_I  = rd_;
            bus.IACK   = rack;
            #1;
            chk($sformatf("rnd%0d_dat_o", n), bus.DAT_O, m_read(ra));
            m_step(r_irq, ra, rwe, rd_, rack);
            tick();
            chk($sformatf("rnd%0d_irq_n", n), bus.IRQ_N, m_irqn);
            chk($sformatf("rnd%0d_ack_valid", n), bus.ACK_VALID, m_av);
            chk($sformatf("rnd%0d_vector", n), bus.VECTOR, m_vec);
        end
        bus.WE   = 1'b0;
        bus.IACK = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
